// File: rtl/pc_sequencer_pkg.sv
// Types and constants shared by the pc sequencer and the branch controller.
package pc_sequencer_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RESOLVE = 2'd2
   } seq_state_e;

   // pcsrc value meaning "fall through to pc+1" when no jump is flagged
   localparam word_t SEQ_SENTINEL = 32'd1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/response and instruction hand-off to the consumer.
interface pc_sequencer_if;
   import pc_sequencer_pkg::*;

   logic  imem_req;
   word_t imem_addr;
   logic  imem_ack;
   word_t imem_rdata;
   logic  instr_valid;
   word_t instruction;
   logic  instr_ready;

   modport master (
      output imem_req, imem_addr, instr_valid, instruction,
      input  imem_ack, imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instruction,
      output imem_ack, imem_rdata, instr_ready
   );

endinterface

// File: rtl/pc_sequencer_pc_next_sel.sv
// Next program counter from branch-control outputs; purely combinational.
module pc_next_sel
   import pc_sequencer_pkg::*;
(
   input  word_t pc,
   input  logic  jf,
   input  word_t pcsrc,
   output word_t pc_next
);

   // With jf set the sentinel value is a real target, not a fall-through.
   always_comb begin
      pc_next = pcsrc;
      if (!jf && (pcsrc == SEQ_SENTINEL)) begin
         pc_next = pc + 32'd1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: one outstanding instruction, pc update on resolve, ack timeout flag.
//   state      | meaning
//   ST_FETCH   | imem_req high at pc, waiting for imem_ack
//   ST_HOLD    | instruction valid, waiting for instr_ready
//   ST_RESOLVE | waiting for resolve strobe to pick next pc
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter word_t       RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned MAX_WAIT     = 16
) (
   input  logic  CLOCK,
   input  logic  RESET_N,
   input  logic  JF,
   input  word_t pcsrc,
   input  logic  resolve,
   output word_t pc,
   output logic  fetch_err,
   pc_sequencer_if.master bus
);

   localparam logic [7:0] WAIT_TC = 8'(MAX_WAIT - 1);

   seq_state_e state_q, state_d;
   word_t      pc_q;
   word_t      pc_next;
   word_t      instr_q;
   logic       fetch_err_q;
   logic [7:0] wait_cnt_q;
   logic       run_q;
   logic       capture;
   logic       load_pc;
   logic       wait_hit;

   pc_next_sel u_pc_next_sel (
      .pc      (pc_q),
      .jf      (JF),
      .pcsrc   (pcsrc),
      .pc_next (pc_next)
   );

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      load_pc = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (run_q && bus.imem_ack) begin
               capture = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.instr_ready) begin
               state_d = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            if (resolve) begin
               load_pc = 1'b1;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // An ack on the terminal cycle wins over the timeout.
   assign wait_hit = run_q && (state_q == ST_FETCH) && !bus.imem_ack &&
                     (wait_cnt_q == WAIT_TC);

   // run_q holds imem_req low through reset until the first edge after release.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_VECTOR;
         instr_q     <= '0;
         fetch_err_q <= 1'b0;
         wait_cnt_q  <= '0;
         run_q       <= 1'b0;
      end else begin
         run_q   <= 1'b1;
         state_q <= state_d;
         if (capture) begin
            instr_q <= bus.imem_rdata;
         end
         if (load_pc) begin
            pc_q <= pc_next;
         end
         if ((state_q != ST_FETCH) || capture) begin
            wait_cnt_q <= '0;
         end else if (run_q) begin
            if (wait_hit) begin
               wait_cnt_q  <= '0;
               fetch_err_q <= 1'b1;
            end else begin
               wait_cnt_q <= wait_cnt_q + 8'd1;
            end
         end
      end
   end

   assign bus.imem_req    = run_q && (state_q == ST_FETCH);
   assign bus.imem_addr   = pc_q;
   assign bus.instr_valid = (state_q == ST_HOLD);
   assign bus.instruction = instr_q;
   assign pc              = pc_q;
   assign fetch_err       = fetch_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch/resolve flow, pc selection, timeout, reset abort.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic  CLOCK   = 1'b0;
   logic  RESET_N = 1'b1;
   logic  JF      = 1'b0;
   logic  resolve = 1'b0;
   word_t pcsrc   = '0;
   word_t pc;
   logic  fetch_err;

   pc_sequencer_if bus_if ();

   pc_sequencer #(
      .RESET_VECTOR (32'h0000_0000),
      .MAX_WAIT     (16)
   ) dut (
      .CLOCK     (CLOCK),
      .RESET_N   (RESET_N),
      .JF        (JF),
      .pcsrc     (pcsrc),
      .resolve   (resolve),
      .pc        (pc),
      .fetch_err (fetch_err),
      .bus       (bus_if)
   );

   always #5 CLOCK = ~CLOCK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   // Entered in a FETCH cycle; acks after n_wait idle request cycles.
   task automatic deliver(input int n_wait, input word_t data, input word_t addr);
      check("req_fetch", {31'd0, bus_if.imem_req}, 32'd1);
      check("addr_fetch", bus_if.imem_addr, addr);
      check("valid_fetch", {31'd0, bus_if.instr_valid}, 32'd0);
      repeat (n_wait) tick();
      check("req_wait", {31'd0, bus_if.imem_req}, 32'd1);
      bus_if.imem_rdata = data;
      bus_if.imem_ack   = 1'b1;
      tick();
      bus_if.imem_ack   = 1'b0;
      check("valid_hold", {31'd0, bus_if.instr_valid}, 32'd1);
      check("instruction", bus_if.instruction, data);
   endtask

   // Entered in the first HOLD cycle with instr_ready high.
   task automatic resolve_to(input logic jf, input word_t src, input word_t exp);
      tick();
      check("valid_resolve", {31'd0, bus_if.instr_valid}, 32'd0);
      check("req_resolve", {31'd0, bus_if.imem_req}, 32'd0);
      JF      = jf;
      pcsrc   = src;
      resolve = 1'b1;
      tick();
      resolve = 1'b0;
      check("req_next", {31'd0, bus_if.imem_req}, 32'd1);
      check("addr_next", bus_if.imem_addr, exp);
      check("pc_next", pc, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.imem_ack    = 1'b0;
      bus_if.imem_rdata  = '0;
      bus_if.instr_ready = 1'b1;

      #1 RESET_N = 1'b0;
      #2;
      check("rst_req", {31'd0, bus_if.imem_req}, 32'd0);
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'd0, bus_if.instr_valid}, 32'd0);
      check("rst_instr", bus_if.instruction, 32'h0);
      check("rst_err", {31'd0, fetch_err}, 32'd0);
      tick();
      check("rst_req_edge", {31'd0, bus_if.imem_req}, 32'd0);
      #5 RESET_N = 1'b1;
      #1 check("req_before_edge", {31'd0, bus_if.imem_req}, 32'd0);
      tick();

      deliver(2, 32'h2000_0005, 32'h0);
      resolve_to(1'b0, 32'd1, 32'h1);
      deliver(0, 32'hA000_0001, 32'h1);
      resolve_to(1'b1, 32'h40, 32'h40);
      deliver(1, 32'hA000_0002, 32'h40);
      resolve_to(1'b1, 32'd1, 32'h1);
      deliver(0, 32'hA000_0003, 32'h1);
      resolve_to(1'b0, 32'h10, 32'h10);
      deliver(0, 32'hA000_0004, 32'h10);
      resolve_to(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      deliver(0, 32'hA000_0005, 32'hFFFF_FFFF);
      resolve_to(1'b0, 32'd1, 32'h0);
      check("wrap_err", {31'd0, fetch_err}, 32'd0);

      // resolve in FETCH and HOLD, acks in HOLD, consumer stalled
      bus_if.instr_ready = 1'b0;
      JF = 1'b1; pcsrc = 32'h99; resolve = 1'b1;
      tick();
      resolve = 1'b0;
      check("fetch_res_pc", pc, 32'h0);
      check("fetch_res_addr", bus_if.imem_addr, 32'h0);
      check("fetch_res_req", {31'd0, bus_if.imem_req}, 32'd1);
      bus_if.imem_rdata = 32'hCAFE_0001;
      bus_if.imem_ack   = 1'b1;
      tick();
      check("stall_valid0", {31'd0, bus_if.instr_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         resolve           = 1'b1;
         bus_if.imem_ack   = 1'b1;
         bus_if.imem_rdata = 32'hDEAD_0000 + i;
         tick();
         check("stall_valid", {31'd0, bus_if.instr_valid}, 32'd1);
         check("stall_instr", bus_if.instruction, 32'hCAFE_0001);
         check("stall_pc", pc, 32'h0);
      end
      resolve            = 1'b0;
      bus_if.imem_ack    = 1'b0;
      bus_if.instr_ready = 1'b1;
      resolve_to(1'b1, 32'h20, 32'h20);

      // timeout at 0x20: flag after 16 idle cycles, retry, ack on cycle 20
      repeat (15) tick();
      check("err_before", {31'd0, fetch_err}, 32'd0);
      tick();
      check("err_set", {31'd0, fetch_err}, 32'd1);
      check("err_req", {31'd0, bus_if.imem_req}, 32'd1);
      check("err_addr", bus_if.imem_addr, 32'h20);
      repeat (3) tick();
      check("err_sticky", {31'd0, fetch_err}, 32'd1);
      bus_if.imem_rdata = 32'h1234_5678;
      bus_if.imem_ack   = 1'b1;
      tick();
      bus_if.imem_ack   = 1'b0;
      check("retry_valid", {31'd0, bus_if.instr_valid}, 32'd1);
      check("retry_instr", bus_if.instruction, 32'h1234_5678);
      resolve_to(1'b1, 32'h30, 32'h30);

      // reset mid-fetch at 0x30
      tick();
      #2 RESET_N = 1'b0;
      #1;
      check("abort_req", {31'd0, bus_if.imem_req}, 32'd0);
      check("abort_pc", pc, 32'h0);
      check("abort_err", {31'd0, fetch_err}, 32'd0);
      #10 RESET_N = 1'b1;
      tick();
      check("rel_err", {31'd0, fetch_err}, 32'd0);

      // ack on the terminal wait cycle is a success
      deliver(15, 32'h5555_AAAA, 32'h0);
      check("tc_ack_err", {31'd0, fetch_err}, 32'd0);
      resolve_to(1'b0, 32'd1, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
